// File: rtl/issue_pkg.sv
// Shared types and constants for the issue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, control-bundle bit positions, default register-index width.
package issue_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } issue_state_t;

    // Bit positions inside the decoded control bundle
    localparam int CTRL_VALID    = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_MEMRE    = 3;
    localparam int CTRL_MEMWR    = 4;

    localparam int NUM_A_REGS_DEF = 32;
    localparam int RW_DEF         = $clog2(NUM_A_REGS_DEF);

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per architectural register with a write in flight.
// Latency: set/clear take effect on the next edge; busy lookups are combinational.
// Backpressure: none; the owner decides when to set, clear or drop.
// Ports: core_clk/arst_n; set_en/set_idx (issue), clr_en/clr_idx (writeback),
//        drop_en/drop_idx (flushed slot); rs1/rs2/rd_idx lookups -> *_busy;
//        any_busy = some register still pending.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int RW       = $clog2(NUM_REGS)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          set_en,
    input  logic [RW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_idx,
    input  logic          drop_en,
    input  logic [RW-1:0] drop_idx,
    input  logic [RW-1:0] rs1_idx,
    input  logic [RW-1:0] rs2_idx,
    input  logic [RW-1:0] rd_idx,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy,
    output logic          any_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] drop_mask;
    logic [NUM_REGS-1:0] eff;

    always_comb begin
        set_mask  = '0;
        wb_mask   = '0;
        drop_mask = '0;
        if (set_en)  set_mask[set_idx]   = 1'b1;
        if (clr_en)  wb_mask[clr_idx]    = 1'b1;
        if (drop_en) drop_mask[drop_idx] = 1'b1;
    end

    // A writeback landing this cycle already unblocks its consumers.
    assign eff = busy_q & ~wb_mask;

    // Set is applied last so a new writer beats a retiring one on the same index.
    always_comb begin
        busy_d    = (busy_q & ~wb_mask & ~drop_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign rs1_busy = eff[rs1_idx];
    assign rs2_busy = eff[rs2_idx];
    assign rd_busy  = eff[rd_idx];
    assign any_busy = |busy_q;

endmodule

// File: rtl/issue_controller.sv
// Issue/hazard controller: one-entry issue register between decode and execute, stalls on RAW/WAW.
// Latency: accepted instruction appears on ex_* one cycle later; same-cycle writeback unblocks a stall.
// Backpressure: dec_ready_o low on hazard, full unaccepted slot, flush, drain or reset; slot holds while ex_ready_i low.
// Ports: clk_i/rst_ni; dec_* handshake + rd/rs1/rs2/alu_op/control; ex_* issue slot with ex_ready_i;
//        wb_valid_i/wb_rd_i retire writes; flush_i starts a drain; illegal_o pulse; drain_busy_o.
// Optional: ISSUE_PERF_CNT_EN adds stall_cnt_o and issue_cnt_o.
module issue_controller
    import issue_pkg::*;
#(
    parameter int NUM_A_REGS           = NUM_A_REGS_DEF,
    parameter int ALU_OP_SIZE          = 4,
    parameter int CONTR_SIG_SIZE       = 5,
    parameter int CONTR_VALID_INDEX    = CTRL_VALID,
    parameter int CONTR_REGWRITE_INDEX = CTRL_REGWRITE,
    localparam int RW                  = $clog2(NUM_A_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dec_valid_i,
    output logic                      dec_ready_o,
    input  logic [RW-1:0]             rd_i,
    input  logic [RW-1:0]             rs1_i,
    input  logic [RW-1:0]             rs2_i,
    input  logic [ALU_OP_SIZE-1:0]    alu_op_i,
    input  logic [CONTR_SIG_SIZE-1:0] control_i,
    output logic                      ex_valid_o,
    input  logic                      ex_ready_i,
    output logic [RW-1:0]             ex_rd_o,
    output logic [RW-1:0]             ex_rs1_o,
    output logic [RW-1:0]             ex_rs2_o,
    output logic [ALU_OP_SIZE-1:0]    ex_alu_op_o,
    output logic [CONTR_SIG_SIZE-1:0] ex_control_o,
    input  logic                      wb_valid_i,
    input  logic [RW-1:0]             wb_rd_i,
    input  logic                      flush_i,
    output logic                      illegal_o,
    output logic                      drain_busy_o
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               issue_cnt_o
`endif
);

    issue_state_t state_q, state_d;

    logic rs1_busy, rs2_busy, rd_busy, any_busy;
    logic ctrl_valid, ctrl_regwrite;
    logic hazard, slot_free, accept, issue, drop;

    assign ctrl_valid    = control_i[CONTR_VALID_INDEX];
    assign ctrl_regwrite = control_i[CONTR_REGWRITE_INDEX];
    assign hazard        = rs1_busy | rs2_busy | (ctrl_regwrite & rd_busy);
    assign slot_free     = ~ex_valid_o | ex_ready_i;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        drain_busy_o = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Invalid instructions are swallowed regardless of hazards.
                    accept  = dec_valid_i & slot_free & (~ctrl_valid | ~hazard);
                    state_d = (dec_valid_i & ctrl_valid & hazard) ? ST_STALL : ST_RUN;
                end
            end
            ST_DRAIN: begin
                drain_busy_o = 1'b1;
                if (!any_busy && !ex_valid_o) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign dec_ready_o = accept & rst_ni;
    assign issue       = accept & ctrl_valid;
    // A flush discards a slot execute has not taken yet; one it takes this cycle stays issued.
    assign drop        = flush_i & (state_q != ST_DRAIN) & ex_valid_o & ~ex_ready_i;

    reg_scoreboard #(
        .NUM_REGS (NUM_A_REGS),
        .RW       (RW)
    ) u_scoreboard (
        .core_clk (clk_i),
        .arst_n   (rst_ni),
        .set_en   (issue & ctrl_regwrite & (rd_i != '0)),
        .set_idx  (rd_i),
        .clr_en   (wb_valid_i),
        .clr_idx  (wb_rd_i),
        .drop_en  (drop & ex_control_o[CONTR_REGWRITE_INDEX]),
        .drop_idx (ex_rd_o),
        .rs1_idx  (rs1_i),
        .rs2_idx  (rs2_i),
        .rd_idx   (rd_i),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o   <= 1'b0;
            ex_rd_o      <= '0;
            ex_rs1_o     <= '0;
            ex_rs2_o     <= '0;
            ex_alu_op_o  <= '0;
            ex_control_o <= '0;
            illegal_o    <= 1'b0;
        end else begin
            illegal_o <= accept & ~ctrl_valid;
            if (issue) begin
                ex_valid_o   <= 1'b1;
                ex_rd_o      <= rd_i;
                ex_rs1_o     <= rs1_i;
                ex_rs2_o     <= rs2_i;
                ex_alu_op_o  <= alu_op_i;
                ex_control_o <= control_i;
            end else if (ex_ready_i || drop) begin
                ex_valid_o <= 1'b0;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            issue_cnt_o <= '0;
        end else begin
            if (state_q == ST_STALL || state_q == ST_DRAIN) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (issue) issue_cnt_o <= issue_cnt_o + 32'd1;
        end
    end
`endif

endmodule
